// File: rtl/shift_chain_ctrl.sv
// Serial shift-chain sequencer: sends a word LSB-first onto a d->q chain and re-captures it.
// Optional SHIFT_CHAIN_CTRL_CHECK_EN keeps a copy of the sent word and flags a mismatch on err.
module shift_chain_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sd,
  input  logic             sq,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIRST_DRAIN = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] FIRST_CAP = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  // tx_reg holds the bits still to be sent; bit 0 is always the next one for sd
  logic [WIDTH-1:0] tx_reg;
  logic [WIDTH-2:0] rx_reg;
  logic [WIDTH-1:0] rx_next;
  logic             capture;

  assign rx_next = {sq, rx_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An out-of-range count for the current state sends the FSM back to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) next_state = SHIFT;
        else          next_state = IDLE;
      end
      SHIFT: begin
        if (cnt > LAST_SHIFT)       next_state = IDLE;
        else if (cnt == LAST_SHIFT) next_state = DRAIN;
        else                        next_state = SHIFT;
      end
      DRAIN: begin
        if ((cnt < FIRST_DRAIN) || (cnt > LAST_DRAIN)) next_state = IDLE;
        else if (cnt == LAST_DRAIN)                    next_state = DONE;
        else                                           next_state = DRAIN;
      end
      DONE: begin
        if (out_ready) next_state = IDLE;
        else           next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      SHIFT:   capture = (cnt >= FIRST_CAP);
      DRAIN:   capture = (cnt >= FIRST_CAP);
      DONE:    out_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd       <= 1'b0;
      tx_reg   <= '0;
      rx_reg   <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      if (capture) begin
        rx_reg <= rx_next[WIDTH-1:1];
      end else begin
        rx_reg <= rx_reg;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            sd     <= in_data[0];
            tx_reg <= in_data >> 1;
            cnt    <= '0;
          end else begin
            sd <= 1'b0;
          end
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (cnt >= LAST_SHIFT) begin
            sd <= 1'b0;
          end else begin
            sd     <= tx_reg[0];
            tx_reg <= tx_reg >> 1;
          end
        end
        DRAIN: begin
          sd  <= 1'b0;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_DRAIN) begin
            out_data <= rx_next;
          end else begin
            out_data <= out_data;
          end
        end
        DONE:    sd <= 1'b0;
        default: sd <= 1'b0;
      endcase
    end
  end

`ifdef SHIFT_CHAIN_CTRL_CHECK_EN
  logic [WIDTH-1:0] copy_reg;

  // Snapshot of the accepted word; err compares the reassembled word against it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copy_reg <= '0;
      err      <= 1'b0;
    end else if ((state == IDLE) && in_valid) begin
      copy_reg <= in_data;
      err      <= 1'b0;
    end else if ((state == DRAIN) && (cnt == LAST_DRAIN)) begin
      err <= (rx_next != copy_reg);
    end else begin
      err <= err;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
